// File: rtl/rx_frame_assembler.sv
// Assembles SYNC/CMD/LEN/payload/CSUM frames from a UART byte stream, holding
// each checked frame until acknowledged and flagging length, checksum, UART and timeout errors.
module rx_frame_assembler #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [7:0]   rx_data,
    input  logic         data_ready,
    input  logic         overrun_error,
    input  logic         framing_error,
    input  logic         frame_ack,
    output logic         frame_valid,
    output logic [7:0]   frame_cmd,
    output logic [4:0]   frame_len,
    output logic [127:0] frame_payload,
    output logic         frame_err,
    output logic [1:0]   err_code
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CSUM, HOLD} state_t;

    state_t         state, state_nxt;
    logic           dr_q, ue_q;
    logic           byte_evt, uart_evt;
    logic           active, timeout, abort;
    logic           err_fire, load_frame;
    logic [1:0]     err_sel;
    logic [7:0]     cmd_r, csum;
    logic [4:0]     len_r;
    logic [3:0]     idx;
    logic [127:0]   payload_r;
    logic [CW-1:0]  tmo_cnt;

    assign byte_evt    = data_ready & ~dr_q;
    assign uart_evt    = (overrun_error | framing_error) & ~ue_q;
    assign active      = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    assign timeout     = active && !byte_evt && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
    assign abort       = active && (uart_evt || timeout);
    assign frame_valid = (state == HOLD);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_fire   = 1'b0;
        err_sel    = 2'b00;
        load_frame = 1'b0;
        // A UART event outranks both a timeout and a simultaneous byte.
        if (abort) begin
            state_nxt = IDLE;
            err_fire  = 1'b1;
            err_sel   = uart_evt ? 2'b10 : 2'b11;
        end else begin
            case (state)
                IDLE:    if (byte_evt && rx_data == SYNC_BYTE) state_nxt = CMD;
                CMD:     if (byte_evt) state_nxt = LEN;
                LEN: begin
                    if (byte_evt) begin
                        if (rx_data == 8'd0 || rx_data > 8'd16) begin
                            state_nxt = IDLE;
                            err_fire  = 1'b1;
                            err_sel   = 2'b00;
                        end else begin
                            state_nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: if (byte_evt && 5'(idx) == len_r - 5'd1) state_nxt = CSUM;
                CSUM: begin
                    if (byte_evt) begin
                        if (rx_data == csum) begin
                            state_nxt  = HOLD;
                            load_frame = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            err_fire  = 1'b1;
                            err_sel   = 2'b01;
                        end
                    end
                end
                HOLD:    if (frame_ack) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dr_q          <= 1'b0;
            ue_q          <= 1'b0;
            tmo_cnt       <= '0;
            cmd_r         <= '0;
            len_r         <= '0;
            idx           <= '0;
            csum          <= '0;
            payload_r     <= '0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            frame_err     <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            dr_q <= data_ready;
            ue_q <= overrun_error | framing_error;

            if (!active || byte_evt) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + CW'(1);

            if (byte_evt && !abort) begin
                case (state)
                    CMD: begin
                        cmd_r <= rx_data;
                        csum  <= rx_data;
                    end
                    LEN: begin
                        len_r     <= rx_data[4:0];
                        idx       <= '0;
                        payload_r <= '0;
                        csum      <= csum ^ rx_data;
                    end
                    PAYLOAD: begin
                        payload_r[{idx, 3'b000} +: 8] <= rx_data;
                        csum <= csum ^ rx_data;
                        idx  <= idx + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (load_frame) begin
                frame_cmd     <= cmd_r;
                frame_len     <= len_r;
                frame_payload <= payload_r;
            end

            frame_err <= err_fire;
            if (err_fire) err_code <= err_sel;
        end
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed scenarios plus random frames checked against a frame-level parser model.
module tb_rx_frame_assembler;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         data_ready = 1'b0;
    logic         overrun_error = 1'b0;
    logic         framing_error = 1'b0;
    logic         frame_ack = 1'b0;
    logic         frame_valid;
    logic [7:0]   frame_cmd;
    logic [4:0]   frame_len;
    logic [127:0] frame_payload;
    logic         frame_err;
    logic [1:0]   err_code;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic         ok;
        logic [1:0]   code;
        logic [7:0]   cmd;
        logic [4:0]   len;
        logic [127:0] pl;
    } outcome_t;

    rx_frame_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .data_ready(data_ready),
        .overrun_error(overrun_error), .framing_error(framing_error),
        .frame_ack(frame_ack), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
        .frame_len(frame_len), .frame_payload(frame_payload),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a point 1 time unit after a rising edge; returns likewise
    // right after the edge on which the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        data_ready = 1'b0;
        @(posedge clk); #1;
        rx_data    = b;
        data_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Frame-level reference: the stream starting at index s is SYNC, CMD, LEN, ...
    function automatic outcome_t predict(input logic [7:0] b[$], input int unsigned s);
        outcome_t    o;
        logic [7:0]  x;
        int unsigned l;
        o = '0;
        o.cmd = b[s+1];
        l = b[s+2];
        if (l == 0 || l > 16) begin
            o.code = 2'b00;
            return o;
        end
        x = b[s+1] ^ b[s+2];
        for (int unsigned k = 0; k < l; k++) begin
            o.pl[8*k +: 8] = b[s+3+k];
            x = x ^ b[s+3+k];
        end
        o.len = 5'(l);
        if (b[s+3+l] == x) o.ok = 1'b1;
        else               o.code = 2'b01;
        return o;
    endfunction

    initial begin
        logic [7:0]   q[$];
        logic [7:0]   bt;
        outcome_t     o;
        int unsigned  junk, lv, d, n;
        logic [7:0]   last_cmd;
        logic [4:0]   last_len;
        logic [127:0] last_pl;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(frame_valid), 128'd0);
        chk("rst_err",   128'(frame_err), 128'd0);
        chk("rst_code",  128'(err_code), 128'd0);
        chk("rst_cmd",   128'(frame_cmd), 128'd0);
        chk("rst_len",   128'(frame_len), 128'd0);
        chk("rst_pl",    frame_payload, 128'd0);
        n_rst = 1'b1;
        cycle();

        // Good frame
        foreach (q[i]) q.delete(i);
        q = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        foreach (q[i]) send_byte(q[i]);
        chk("good_valid", 128'(frame_valid), 128'd1);
        chk("good_cmd",   128'(frame_cmd), 128'h01);
        chk("good_len",   128'(frame_len), 128'd2);
        chk("good_pl",    frame_payload, 128'h2211);
        chk("good_noerr", 128'(frame_err), 128'd0);
        // Bytes and UART events while holding are ignored
        send_byte(8'h5A);
        data_ready = 1'b0;
        overrun_error = 1'b1;
        cycle();
        overrun_error = 1'b0;
        cycle();
        chk("hold_valid", 128'(frame_valid), 128'd1);
        chk("hold_noerr", 128'(frame_err), 128'd0);
        chk("hold_pl",    frame_payload, 128'h2211);
        // SYNC arriving in the ack cycle is dropped
        rx_data = 8'hA5;
        data_ready = 1'b1;
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        chk("ack_valid", 128'(frame_valid), 128'd0);
        q = '{8'h01, 8'h01, 8'h55, 8'h55};
        foreach (q[i]) send_byte(q[i]);
        cycle();
        chk("ack_sync_dropped", 128'(frame_valid), 128'd0);
        chk("ack_sync_noerr",   128'(frame_err), 128'd0);

        // Checksum error
        q = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
        foreach (q[i]) send_byte(q[i]);
        chk("csum_err",    128'(frame_err), 128'd1);
        chk("csum_code",   128'(err_code), 128'd1);
        chk("csum_valid",  128'(frame_valid), 128'd0);
        chk("csum_retain", 128'(frame_cmd), 128'h01);
        cycle();
        chk("csum_pulse",  128'(frame_err), 128'd0);
        chk("csum_code_hold", 128'(err_code), 128'd1);

        // Length zero
        q = '{8'hA5, 8'h07, 8'h00};
        foreach (q[i]) send_byte(q[i]);
        chk("len0_err",  128'(frame_err), 128'd1);
        chk("len0_code", 128'(err_code), 128'd0);

        // UART error together with a byte edge
        q = '{8'hA5, 8'h01, 8'h02, 8'h11};
        foreach (q[i]) send_byte(q[i]);
        data_ready = 1'b0;
        cycle();
        rx_data = 8'h22;
        data_ready = 1'b1;
        framing_error = 1'b1;
        cycle();
        chk("uart_err",  128'(frame_err), 128'd1);
        chk("uart_code", 128'(err_code), 128'd2);
        framing_error = 1'b0;
        send_byte(8'h30);
        cycle();
        chk("uart_byte_ignored", 128'(frame_valid), 128'd0);
        chk("uart_no_more_err",  128'(frame_err), 128'd0);

        // Length 17
        q = '{8'hA5, 8'h07, 8'h11};
        foreach (q[i]) send_byte(q[i]);
        chk("len17_err",  128'(frame_err), 128'd1);
        chk("len17_code", 128'(err_code), 128'd0);

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h01);
        data_ready = 1'b0;
        n = 0;
        while (n < 1200 && !frame_err) begin
            cycle();
            n++;
        end
        chk("tmo_cycles", 128'(n), 128'd1000);
        chk("tmo_code",   128'(err_code), 128'd3);
        q = '{8'hA5, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h01};
        foreach (q[i]) send_byte(q[i]);
        chk("tmo_next_valid", 128'(frame_valid), 128'd1);
        chk("tmo_next_pl",    frame_payload, 128'h302010);
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;

        // Reset in the middle of a frame
        q = '{8'hA5, 8'h01, 8'h04, 8'hAA};
        foreach (q[i]) send_byte(q[i]);
        #2;
        n_rst = 1'b0;
        data_ready = 1'b0;
        #1;
        chk("mrst_cmd",  128'(frame_cmd), 128'd0);
        chk("mrst_len",  128'(frame_len), 128'd0);
        chk("mrst_pl",   frame_payload, 128'd0);
        chk("mrst_code", 128'(err_code), 128'd0);
        cycle();
        n_rst = 1'b1;
        q = '{8'hA5, 8'h03, 8'h01, 8'h55, 8'h57};
        foreach (q[i]) send_byte(q[i]);
        chk("post_rst_valid", 128'(frame_valid), 128'd1);
        chk("post_rst_cmd",   128'(frame_cmd), 128'h03);
        chk("post_rst_len",   128'(frame_len), 128'd1);
        chk("post_rst_pl",    frame_payload, 128'h55);
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        last_cmd = 8'h03;
        last_len = 5'd1;
        last_pl  = 128'h55;

        // Random frames
        for (int it = 0; it < 40; it++) begin
            q.delete();
            junk = $urandom_range(0, 2);
            for (int unsigned j = 0; j < junk; j++) begin
                bt = 8'($urandom);
                if (bt == 8'hA5) bt = 8'h00;
                q.push_back(bt);
            end
            q.push_back(8'hA5);
            bt = 8'($urandom);
            q.push_back(bt);
            d = $urandom_range(0, 9);
            if (d == 0)      lv = 0;
            else if (d == 1) lv = $urandom_range(17, 255);
            else             lv = $urandom_range(1, 16);
            q.push_back(8'(lv));
            if (lv >= 1 && lv <= 16) begin
                bt = bt ^ 8'(lv);
                for (int unsigned k = 0; k < lv; k++) begin
                    q.push_back(8'($urandom));
                    bt = bt ^ q[q.size()-1];
                end
                if ($urandom_range(0, 3) == 0) bt = bt ^ 8'($urandom_range(1, 255));
                q.push_back(bt);
            end
            o = predict(q, junk);
            foreach (q[i]) send_byte(q[i]);
            if (o.ok) begin
                last_cmd = o.cmd;
                last_len = o.len;
                last_pl  = o.pl;
            end
            chk("rnd_valid", 128'(frame_valid), 128'(o.ok));
            chk("rnd_err",   128'(frame_err), 128'(!o.ok));
            chk("rnd_cmd",   128'(frame_cmd), 128'(last_cmd));
            chk("rnd_len",   128'(frame_len), 128'(last_len));
            chk("rnd_pl",    frame_payload, last_pl);
            if (!o.ok) begin
                chk("rnd_code", 128'(err_code), 128'(o.code));
                cycle();
                chk("rnd_err_pulse", 128'(frame_err), 128'd0);
            end else begin
                d = $urandom_range(0, 3);
                repeat (d) cycle();
                chk("rnd_hold", 128'(frame_valid), 128'd1);
                frame_ack = 1'b1;
                cycle();
                frame_ack = 1'b0;
                chk("rnd_ack", 128'(frame_valid), 128'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
